filter_stream_ctrl: RTL and testbench
=====================================

# filter_stream_ctrl

Front-end sequencer for the FIR filter block: accepts ADC samples over a valid/ready handshake, buffers them in a small FIFO, and feeds one sample at a time to the filter. Each sample is issued with a single-cycle `filter_enable` pulse on `filter_data_out`. The controller then waits for `filter_done`, captures `filter_data_in`, and presents the result on a valid/ready output stream. It is the initiator side of the filter's enable/done protocol and sits between the ADC capture logic and downstream sample consumers.

## Interface
- `DATA_WIDTH`, 16, sample width in/out
- `FIFO_DEPTH`, 4, input FIFO entries; power of two, ≥2
- `TIMEOUT_CYCLES`, 8, WAIT edges allowed without `filter_done`; ≥2

- `clk_out`  in  1  clock, all logic rising-edge
- `reset`  in  1  asynchronous, active-high
- `adc_valid`  in  1  ADC sample valid
- `adc_data`  in  DATA_WIDTH  ADC sample
- `adc_ready`  out  1  FIFO can accept; `fifo_count < FIFO_DEPTH`
- `filter_enable`  out  1  one-cycle issue pulse to filter
- `filter_data_out`  out  DATA_WIDTH  sample presented to filter, registered
- `filter_done`  in  1  filter completion
- `filter_data_in`  in  DATA_WIDTH  filter result
- `out_valid`  out  1  result available
- `out_data`  out  DATA_WIDTH  filter result, held while `out_valid`
- `out_ready`  in  1  downstream accepts
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
- `timeout_err`  out  1  sticky; set on filter timeout
- `clear_err`  in  1  clears `timeout_err`

## Operation
- Reset values: `filter_enable`=0, `filter_data_out`=0, `out_valid`=0, `out_data`=0, `fifo_count`=0, `timeout_err`=0. FIFO pointers are 0, FSM is IDLE, timeout counter is 0. `adc_ready`=1 once reset deasserts.
- FIFO push: on an edge where `adc_valid & adc_ready`. Pointers wrap modulo `FIFO_DEPTH`.
- FIFO pop: only on ISSUE.
- When full, `adc_ready`=0 and no push occurs, even if a pop occurs on the same edge.
- Simultaneous push and pop leaves `fifo_count` unchanged.
- FSM IDLE: at an edge with `fifo_count>0` and `out_valid==0`:
  - `filter_data_out`←FIFO head, `filter_enable`←1, pop
  - timeout counter←0
  - go to WAIT
- FSM WAIT, every edge:
  - `filter_enable`←0
  - If `filter_done`==1: `out_data`←`filter_data_in`, `out_valid`←1, go to IDLE.
  - Else if the counter reaches `TIMEOUT_CYCLES-1`: `timeout_err`←1, the sample is dropped, go to IDLE.
  - Else: counter+1.
- `filter_done` seen on the first WAIT edge (the edge at which the filter samples enable) is ignored. Completion is accepted from the second WAIT edge onward.
- Output handshake: the transfer occurs at an edge with `out_valid & out_ready`, and `out_valid`←0. `out_data` is stable until then.
- IDLE issues only when the registered `out_valid` is 0. A transfer on edge E permits an issue at edge E+1 at the earliest.
- `timeout_err`: `clear_err` clears it. If a timeout and `clear_err` occur on the same edge, set wins.
- Result arithmetic: none. `filter_data_in` is captured verbatim, all `DATA_WIDTH` bits.

## Timing
- Push at edge P into an empty FIFO, with the FSM in IDLE and `out_valid`=0:
  - ISSUE at P+1
  - `filter_enable` high between P+1 and P+2
  - filter asserts done after P+2
  - capture at edge P+3
  - `out_valid`=1 after P+3
- Push-to-`out_valid` latency is 3 cycles.
- Steady-state throughput with `out_ready`=1: one result per 4 cycles (issue, wait, capture, transfer).
- `filter_enable` is never high for more than one consecutive cycle.
- Reset asserted mid-operation immediately forces all outputs to reset values and drops FIFO contents and any in-flight sample. No `out_valid` appears for pre-reset samples.
- Timeout path: with no done, `timeout_err` rises after the `TIMEOUT_CYCLES`-th WAIT edge. The next issue happens no earlier than the following edge.

## Test plan
- Single sample: push 0x0010, filter model returns 0x0030 with done one cycle after enable. Require one `filter_enable` pulse carrying 0x0010, `out_valid` 3 cycles after push, `out_data`=0x0030.
- FIFO full: hold `out_ready`=0 and push 6 samples 1..6 with `FIFO_DEPTH`=4. Require:
  - sample 1 issued; samples 2–5 buffered
  - `fifo_count`=4 and `adc_ready`=0 while sample 6 is held
  - after releasing `out_ready`, outputs appear in order 1..6 with none lost
- Backpressure: `out_ready`=0 for 10 cycles with a result pending. Require `out_data` stable, no further `filter_enable` pulses, and FIFO preserved.
- Timeout: the filter model never asserts done. Require `timeout_err`=1 after 8 WAIT edges, no `out_valid`, and the next sample still issued. `clear_err` then gives `timeout_err`=0. With timeout and `clear_err` on the same edge, require `timeout_err`=1.
- Reset mid-WAIT with 3 samples buffered. Require all outputs 0 immediately, `fifo_count`=0, `adc_ready`=1 after release, and no stale results afterward.
- Simultaneous push/pop at `fifo_count`=2: require `fifo_count` stays 2, with correct pointer wrap across 10 consecutive samples.

Source files
------------

// File: rtl/filter_stream_ctrl_if.sv
// Handshake bundle between the filter front-end sequencer and its neighbours:
// ADC sample input stream, filter enable/done issue port, result output stream.
interface filter_stream_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 16
);
  // ADC capture side
  logic                  adc_valid;
  logic [DATA_WIDTH-1:0] adc_data;
  logic                  adc_ready;
  // FIR filter side
  logic                  filter_enable;
  logic [DATA_WIDTH-1:0] filter_data_out;
  logic                  filter_done;
  logic [DATA_WIDTH-1:0] filter_data_in;
  // Result stream
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_ready;

  // Controller view
  modport master (
    input  adc_valid, adc_data, filter_done, filter_data_in, out_ready,
    output adc_ready, filter_enable, filter_data_out, out_valid, out_data
  );

  // Environment view (ADC, filter and downstream consumer)
  modport slave (
    output adc_valid, adc_data, filter_done, filter_data_in, out_ready,
    input  adc_ready, filter_enable, filter_data_out, out_valid, out_data
  );
endinterface

// File: rtl/filter_stream_ctrl.sv
// FIR front-end sequencer: buffers ADC samples in a small FIFO, issues one
// sample at a time to the filter with a single-cycle enable pulse, waits for
// done (with timeout), and presents the captured result on a valid/ready stream.
module filter_stream_ctrl #(
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 8
) (
  input  logic                          clk_out,
  input  logic                          reset,
  filter_stream_ctrl_if.master          bus,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          timeout_err,
  input  logic                          clear_err
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  state_t                state_q, state_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fdo_q, fdo_d;
  logic                  en_q, en_d;
  logic                  ov_q, ov_d;
  logic [DATA_WIDTH-1:0] od_q, od_d;
  logic [TW-1:0]         tcnt_q, tcnt_d;
  logic                  terr_q, terr_d;

  logic adc_ready;
  logic push;
  logic issue;

  assign adc_ready = (count_q < CW'(FIFO_DEPTH));
  assign push      = bus.adc_valid && adc_ready;
  // Issue needs the registered out_valid low, so a result transfer at edge E
  // allows the next issue at E+1 at the earliest.
  assign issue     = (state_q == S_IDLE) && (count_q != '0) && !ov_q;

  assign bus.adc_ready       = adc_ready;
  assign bus.filter_enable   = en_q;
  assign bus.filter_data_out = fdo_q;
  assign bus.out_valid       = ov_q;
  assign bus.out_data        = od_q;
  assign fifo_count          = count_q;
  assign timeout_err         = terr_q;

  // Next-state logic: FIFO bookkeeping, issue/wait sequencing, output handshake
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    fdo_d    = fdo_q;
    en_d     = 1'b0;
    ov_d     = ov_q;
    od_d     = od_q;
    tcnt_d   = tcnt_q;
    terr_d   = terr_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end

    unique case ({push, issue})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (ov_q && bus.out_ready) begin
      ov_d = 1'b0;
    end

    if (clear_err) begin
      terr_d = 1'b0;
    end

    unique case (state_q)
      S_IDLE: begin
        if (issue) begin
          fdo_d    = mem_q[rd_ptr_q];
          en_d     = 1'b1;
          rd_ptr_d = rd_ptr_q + PW'(1);
          tcnt_d   = '0;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        // tcnt_q==0 marks the edge where the filter samples enable; a done
        // seen there belongs to nothing we issued and is ignored.
        if (bus.filter_done && (tcnt_q != '0)) begin
          od_d    = bus.filter_data_in;
          ov_d    = 1'b1;
          state_d = S_IDLE;
        end else if (tcnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
          terr_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          tcnt_d  = tcnt_q + TW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and datapath registers with asynchronous reset
  always_ff @(posedge clk_out or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      fdo_q    <= '0;
      en_q     <= 1'b0;
      ov_q     <= 1'b0;
      od_q     <= '0;
      tcnt_q   <= '0;
      terr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      fdo_q    <= fdo_d;
      en_q     <= en_d;
      ov_q     <= ov_d;
      od_q     <= od_d;
      tcnt_q   <= tcnt_d;
      terr_q   <= terr_d;
    end
  end

  // FIFO storage; contents are don't-care while count is zero, so no reset
  always_ff @(posedge clk_out) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus.adc_data;
    end
  end

endmodule

// File: tb/tb_filter_stream_ctrl.sv
// Directed bench for filter_stream_ctrl: cycle-accurate vector table for the
// single-sample and back-to-back path, then hand sequences for FIFO full,
// backpressure, timeout, reset mid-wait and simultaneous push/pop.
module tb_filter_stream_ctrl;

  logic       clk_out = 1'b0;
  logic       reset;
  logic       clear_err;
  logic [2:0] fifo_count;
  logic       timeout_err;

  filter_stream_ctrl_if #(.DATA_WIDTH(16)) bus();

  filter_stream_ctrl #(
    .DATA_WIDTH    (16),
    .FIFO_DEPTH    (4),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk_out    (clk_out),
    .reset      (reset),
    .bus        (bus),
    .fifo_count (fifo_count),
    .timeout_err(timeout_err),
    .clear_err  (clear_err)
  );

  always #5 clk_out = ~clk_out;

  // Filter model: mode 0 = done one cycle after enable, result = 3*sample;
  // mode 1 = never done; mode 2 = done only while enable is high (too early).
  int          mode = 0;
  logic        done_q = 1'b0;
  logic [15:0] din_q = '0;
  always @(posedge clk_out) begin
    done_q <= (mode == 0) && bus.filter_enable;
    din_q  <= 16'(bus.filter_data_out * 16'd3);
  end
  assign bus.filter_done    = (mode == 2) ? bus.filter_enable : done_q;
  assign bus.filter_data_in = din_q;

  // Output/enable monitor
  logic [15:0] got[$];
  int          en_pulses = 0;
  int          dbl = 0;
  logic        en_prev = 1'b0;
  always @(posedge clk_out) begin
    if (bus.out_valid && bus.out_ready) got.push_back(bus.out_data);
    if (bus.filter_enable) en_pulses <= en_pulses + 1;
    if (bus.filter_enable && en_prev) dbl <= dbl + 1;
    en_prev <= bus.filter_enable;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_out);
    #1;
  endtask

  task automatic push(input logic [15:0] d);
    logic ok;
    ok = 1'b0;
    bus.adc_valid = 1'b1;
    bus.adc_data  = d;
    for (int i = 0; i < 50 && !ok; i++) begin
      ok = bus.adc_ready;
      step();
    end
    bus.adc_valid = 1'b0;
    chk("push_accept", {31'd0, ok}, 32'd1);
  endtask

  task automatic wait_got(input int n, input int budget);
    int c;
    c = 0;
    while (got.size() < n && c < budget) begin
      step();
      c++;
    end
    chk("drain_count", got.size(), n);
  endtask

  typedef struct {
    logic        v;
    logic [15:0] d;
    logic        ordy;
    logic        en;
    logic [15:0] fdo;
    logic        ov;
    logic [15:0] od;
    logic [2:0]  cnt;
    logic        ardy;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int base;
    int en0;
    logic ok;

    // inputs: valid, data, out_ready | expected after edge: en, fdo, ov, od, count, adc_ready
    tbl[0] = '{1'b1, 16'h0010, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 3'd1, 1'b1};
    tbl[1] = '{1'b1, 16'h0021, 1'b1, 1'b1, 16'h0010, 1'b0, 16'h0000, 3'd1, 1'b1};
    tbl[2] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0010, 1'b0, 16'h0000, 3'd1, 1'b1};
    tbl[3] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0010, 1'b1, 16'h0030, 3'd1, 1'b1};
    tbl[4] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0010, 1'b1, 16'h0030, 3'd1, 1'b1};
    tbl[5] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0010, 1'b0, 16'h0030, 3'd1, 1'b1};
    tbl[6] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0021, 1'b0, 16'h0030, 3'd0, 1'b1};
    tbl[7] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0021, 1'b0, 16'h0030, 3'd0, 1'b1};
    tbl[8] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0021, 1'b1, 16'h0063, 3'd0, 1'b1};
    tbl[9] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0021, 1'b0, 16'h0063, 3'd0, 1'b1};

    reset         = 1'b1;
    clear_err     = 1'b0;
    bus.adc_valid = 1'b0;
    bus.adc_data  = '0;
    bus.out_ready = 1'b0;

    // Reset state
    repeat (2) step();
    chk("rst_en", {31'd0, bus.filter_enable}, 32'd0);
    chk("rst_fdo", {16'd0, bus.filter_data_out}, 32'd0);
    chk("rst_ov", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_od", {16'd0, bus.out_data}, 32'd0);
    chk("rst_cnt", {29'd0, fifo_count}, 32'd0);
    chk("rst_terr", {31'd0, timeout_err}, 32'd0);
    reset = 1'b0;
    #1;
    chk("rst_ardy", {31'd0, bus.adc_ready}, 32'd1);

    // Single sample plus back-to-back second sample, cycle by cycle
    for (int i = 0; i < 10; i++) begin
      bus.adc_valid = tbl[i].v;
      bus.adc_data  = tbl[i].d;
      bus.out_ready = tbl[i].ordy;
      step();
      chk($sformatf("vec%0d_en", i), {31'd0, bus.filter_enable}, {31'd0, tbl[i].en});
      chk($sformatf("vec%0d_fdo", i), {16'd0, bus.filter_data_out}, {16'd0, tbl[i].fdo});
      chk($sformatf("vec%0d_ov", i), {31'd0, bus.out_valid}, {31'd0, tbl[i].ov});
      chk($sformatf("vec%0d_od", i), {16'd0, bus.out_data}, {16'd0, tbl[i].od});
      chk($sformatf("vec%0d_cnt", i), {29'd0, fifo_count}, {29'd0, tbl[i].cnt});
      chk($sformatf("vec%0d_ardy", i), {31'd0, bus.adc_ready}, {31'd0, tbl[i].ardy});
    end
    bus.adc_valid = 1'b0;

    // FIFO full: out_ready low, push 1..6
    base = got.size();
    en0  = en_pulses;
    bus.out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) push(16'(i));
    bus.adc_valid = 1'b1;
    bus.adc_data  = 16'd6;
    repeat (3) step();
    chk("full_cnt", {29'd0, fifo_count}, 32'd4);
    chk("full_ardy", {31'd0, bus.adc_ready}, 32'd0);
    chk("full_ov", {31'd0, bus.out_valid}, 32'd1);
    chk("full_od", {16'd0, bus.out_data}, 32'd3);
    chk("full_issues", en_pulses - en0, 32'd1);
    bus.out_ready = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      ok = bus.adc_ready;
      step();
    end
    bus.adc_valid = 1'b0;
    chk("full_push6", {31'd0, ok}, 32'd1);
    wait_got(base + 6, 100);
    for (int i = 0; i < 6; i++)
      if (got.size() > base + i)
        chk($sformatf("full_out%0d", i + 1), {16'd0, got[base + i]}, 32'(3 * (i + 1)));

    // Backpressure: result pending for 10 cycles with another sample queued
    base = got.size();
    bus.out_ready = 1'b0;
    push(16'h0100);
    push(16'h0200);
    repeat (2) step();
    en0 = en_pulses;
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("bp_od%0d", i), {16'd0, bus.out_data}, 32'h0300);
      chk($sformatf("bp_ov%0d", i), {31'd0, bus.out_valid}, 32'd1);
    end
    chk("bp_no_issue", en_pulses - en0, 32'd0);
    chk("bp_cnt", {29'd0, fifo_count}, 32'd1);
    bus.out_ready = 1'b1;
    wait_got(base + 2, 50);
    if (got.size() >= base + 2) begin
      chk("bp_out0", {16'd0, got[base]}, 32'h0300);
      chk("bp_out1", {16'd0, got[base + 1]}, 32'h0600);
    end

    // Timeout: filter never answers, following sample still issued
    base = got.size();
    mode = 1;
    bus.out_ready = 1'b0;
    push(16'h0055);
    push(16'h0066);
    repeat (7) step();
    chk("to_before", {31'd0, timeout_err}, 32'd0);
    step();
    chk("to_set", {31'd0, timeout_err}, 32'd1);
    chk("to_no_ov", {31'd0, bus.out_valid}, 32'd0);
    step();
    chk("to_next_en", {31'd0, bus.filter_enable}, 32'd1);
    chk("to_next_fdo", {16'd0, bus.filter_data_out}, 32'h0066);
    mode = 0;
    for (int i = 0; i < 10 && !bus.out_valid; i++) step();
    chk("to_next_ov", {31'd0, bus.out_valid}, 32'd1);
    chk("to_next_od", {16'd0, bus.out_data}, 32'h0132);
    chk("to_sticky", {31'd0, timeout_err}, 32'd1);
    clear_err = 1'b1;
    step();
    clear_err = 1'b0;
    chk("to_clear", {31'd0, timeout_err}, 32'd0);
    bus.out_ready = 1'b1;
    step();
    chk("to_outputs", got.size() - base, 32'd1);

    // Timeout and clear on the same edge: set wins
    mode = 1;
    push(16'h0077);
    step();
    repeat (7) step();
    chk("sw_before", {31'd0, timeout_err}, 32'd0);
    clear_err = 1'b1;
    step();
    clear_err = 1'b0;
    chk("sw_set_wins", {31'd0, timeout_err}, 32'd1);
    clear_err = 1'b1;
    step();
    clear_err = 1'b0;
    chk("sw_clear", {31'd0, timeout_err}, 32'd0);

    // Done only on the first WAIT edge is ignored, so it times out
    base = got.size();
    mode = 2;
    push(16'h0088);
    repeat (8) step();
    chk("early_before", {31'd0, timeout_err}, 32'd0);
    step();
    chk("early_to", {31'd0, timeout_err}, 32'd1);
    chk("early_no_out", got.size() - base, 32'd0);
    clear_err = 1'b1;
    step();
    clear_err = 1'b0;

    // Reset mid-WAIT with three samples buffered
    mode = 1;
    bus.out_ready = 1'b0;
    push(16'h00A1);
    push(16'h00A2);
    push(16'h00A3);
    push(16'h00A4);
    chk("rw_pre_cnt", {29'd0, fifo_count}, 32'd3);
    chk("rw_pre_fdo", {16'd0, bus.filter_data_out}, 32'h00A1);
    #2;
    reset = 1'b1;
    #1;
    chk("rw_en", {31'd0, bus.filter_enable}, 32'd0);
    chk("rw_fdo", {16'd0, bus.filter_data_out}, 32'd0);
    chk("rw_ov", {31'd0, bus.out_valid}, 32'd0);
    chk("rw_od", {16'd0, bus.out_data}, 32'd0);
    chk("rw_cnt", {29'd0, fifo_count}, 32'd0);
    chk("rw_terr", {31'd0, timeout_err}, 32'd0);
    #3;
    reset = 1'b0;
    #1;
    chk("rw_ardy", {31'd0, bus.adc_ready}, 32'd1);
    mode = 0;
    bus.out_ready = 1'b1;
    base = got.size();
    en0  = en_pulses;
    repeat (10) step();
    chk("rw_no_stale", got.size() - base, 32'd0);
    chk("rw_no_issue", en_pulses - en0, 32'd0);
    push(16'h00BB);
    wait_got(base + 1, 20);
    if (got.size() > base) chk("rw_after", {16'd0, got[base]}, 32'h0231);

    // Simultaneous push/pop at count 2, ten samples across pointer wrap
    base = got.size();
    push(16'h1000);
    push(16'h1001);
    push(16'h1002);
    chk("pp_pre_cnt", {29'd0, fifo_count}, 32'd2);
    for (int k = 0; k < 10; k++) begin
      repeat ((k == 0) ? 2 : 3) step();
      bus.adc_valid = 1'b1;
      bus.adc_data  = 16'h1003 + 16'(k);
      step();
      bus.adc_valid = 1'b0;
      chk($sformatf("pp_cnt%0d", k), {29'd0, fifo_count}, 32'd2);
      chk($sformatf("pp_en%0d", k), {31'd0, bus.filter_enable}, 32'd1);
    end
    wait_got(base + 13, 200);
    for (int i = 0; i < 13; i++)
      if (got.size() > base + i)
        chk($sformatf("pp_out%0d", i), {16'd0, got[base + i]}, 32'(16'(3 * (16'h1000 + i))));

    chk("enable_single_cycle", dbl, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
